// File: rtl/lookup2_ctrl_pkg.sv
// Shared definitions for the lookup2 hash controller: golden ratio seed,
// controller states, mix shift amounts and the per-round mix function.
package lookup2_ctrl_pkg;

  localparam logic [31:0] GOLDEN = 32'h9e3779b9;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MIX  = 3'd2,
    TAIL = 3'd3,
    TMIX = 3'd4,
    DONE = 3'd5
  } state_t;

  // Shift amounts of the three mix rounds (a-line, b-line, c-line).
  localparam int unsigned SH_A1 = 13;
  localparam int unsigned SH_B1 = 8;
  localparam int unsigned SH_C1 = 13;
  localparam int unsigned SH_A2 = 12;
  localparam int unsigned SH_B2 = 16;
  localparam int unsigned SH_C2 = 5;
  localparam int unsigned SH_A3 = 3;
  localparam int unsigned SH_B3 = 10;
  localparam int unsigned SH_C3 = 15;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } abc_t;

  // One three-line mix round; b and c lines consume the freshly updated values.
  function automatic abc_t mix_round(abc_t v, int unsigned sa, int unsigned sb,
                                     int unsigned sc);
    abc_t r;
    r.a = (v.a - v.b - v.c) ^ (v.c >> sa);
    r.b = (v.b - v.c - r.a) ^ (r.a << sb);
    r.c = (v.c - r.a - r.b) ^ (r.b >> sc);
    return r;
  endfunction

  // Keep the first nbytes bytes of a little-endian word, zero the rest.
  function automatic logic [31:0] mask_tail(logic [31:0] w, logic [3:0] nbytes);
    logic [31:0] m;
    m = w;
    for (int i = 0; i < 4; i++) begin
      if (4'(i) >= nbytes) m[8*i +: 8] = 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/lookup2_ctrl_if.sv
// Job, key-stream and result signals of the lookup2 controller.
interface lookup2_ctrl_if #(
  parameter int LEN_W = 16
);
  // start is sampled only while the controller is idle. key_data moves on a
  // rising edge where key_valid && key_ready; hash moves where
  // hash_valid && hash_ready. A raised valid holds its data until accepted.
  logic             start;
  logic [31:0]      initval;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             key_valid;
  logic [31:0]      key_data;
  logic             key_ready;
  logic             hash_valid;
  logic [31:0]      hash;
  logic             hash_ready;

  modport master (
    output start, initval, len, key_valid, key_data, hash_ready,
    input  busy, key_ready, hash_valid, hash
  );

  modport slave (
    input  start, initval, len, key_valid, key_data, hash_ready,
    output busy, key_ready, hash_valid, hash
  );

endinterface

// File: rtl/lookup2_mix.sv
// Three-cycle lookup2 mix engine: one mix round per cycle, done pulses in
// the third cycle after start with the mixed values on a_out/b_out/c_out.
module lookup2_mix
  import lookup2_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [31:0] c_in,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [31:0] c_out,
  output logic        done
);

  logic [1:0] stage_q;
  abc_t       st_q;
  abc_t       in_v;
  abc_t       nxt;

  assign in_v = '{a: a_in, b: b_in, c: c_in};

  always_comb begin
    nxt = st_q;
    case (stage_q)
      2'd0:    nxt = mix_round(in_v, SH_A1, SH_B1, SH_C1);
      2'd1:    nxt = mix_round(st_q, SH_A2, SH_B2, SH_C2);
      2'd2:    nxt = mix_round(st_q, SH_A3, SH_B3, SH_C3);
      default: nxt = st_q;
    endcase
  end

  // stage 3 is the done cycle; the engine falls back to idle right after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= 2'd0;
      st_q    <= '0;
    end else begin
      case (stage_q)
        2'd0: begin
          if (start) begin
            st_q    <= nxt;
            stage_q <= 2'd1;
          end
        end
        2'd1: begin
          st_q    <= nxt;
          stage_q <= 2'd2;
        end
        2'd2: begin
          st_q    <= nxt;
          stage_q <= 2'd3;
        end
        default: stage_q <= 2'd0;
      endcase
    end
  end

  assign done  = (stage_q == 2'd3);
  assign a_out = st_q.a;
  assign b_out = st_q.b;
  assign c_out = st_q.c;

endmodule

// File: rtl/lookup2_ctrl.sv
// lookup2 hash sequencer: accumulates 12-byte key blocks, folds in the
// masked tail and length, and runs every mix on a shared lookup2_mix engine.
module lookup2_ctrl
  import lookup2_ctrl_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  lookup2_ctrl_if.slave  bus,
  output state_t         dbg_state
);

  state_t           state_q, state_d;
  logic [31:0]      a_q, a_d, b_q, b_d, c_q, c_d;
  logic [LEN_W-1:0] rem_q, rem_d, len_q, len_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       owed_q, owed_d;
  logic [31:0]      hash_q, hash_d;
  logic             mix_busy_q, mix_busy_d;

  logic             key_ready_c;
  logic             mix_start;
  logic             mix_done;
  logic [31:0]      mix_a, mix_b, mix_c;
  logic [3:0]       tail_t;
  logic [3:0]       tail_bytes;
  logic [31:0]      tail_word;

  lookup2_mix u_mix (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mix_start),
    .a_in  (a_q),
    .b_in  (b_q),
    .c_in  (c_q),
    .a_out (mix_a),
    .b_out (mix_b),
    .c_out (mix_c),
    .done  (mix_done)
  );

  // Tail words owed = ceil(rem/4); only meaningful once rem < 12.
  assign tail_t     = rem_q[3:0] + 4'd3;
  assign tail_bytes = rem_q[3:0] - {cnt_q, 2'b00};
  assign tail_word  = mask_tail(bus.key_data, tail_bytes);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    rem_d       = rem_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    owed_d      = owed_q;
    hash_d      = hash_q;
    mix_busy_d  = mix_busy_q;
    key_ready_c = 1'b0;
    mix_start   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = GOLDEN;
          b_d     = GOLDEN;
          c_d     = bus.initval;
          rem_d   = bus.len;
          len_d   = bus.len;
          cnt_d   = 2'd0;
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (rem_q >= LEN_W'(12)) begin
          key_ready_c = 1'b1;
          if (bus.key_valid) begin
            case (cnt_q)
              2'd0:    a_d = a_q + bus.key_data;
              2'd1:    b_d = b_q + bus.key_data;
              default: c_d = c_q + bus.key_data;
            endcase
            if (cnt_q == 2'd2) begin
              cnt_d   = 2'd0;
              rem_d   = rem_q - LEN_W'(12);
              state_d = MIX;
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
          end
        end else begin
          c_d     = c_q + 32'(len_q);
          owed_d  = tail_t[3:2];
          cnt_d   = 2'd0;
          state_d = TAIL;
        end
      end

      TAIL: begin
        if (cnt_q != owed_q) begin
          key_ready_c = 1'b1;
          if (bus.key_valid) begin
            case (cnt_q)
              2'd0:    a_d = a_q + tail_word;
              2'd1:    b_d = b_q + tail_word;
              default: c_d = c_q + {tail_word[23:0], 8'h00};
            endcase
            cnt_d = cnt_q + 2'd1;
            if (cnt_q + 2'd1 == owed_q) state_d = TMIX;
          end
        end else begin
          state_d = TMIX;
        end
      end

      MIX, TMIX: begin
        if (!mix_busy_q) begin
          mix_start  = 1'b1;
          mix_busy_d = 1'b1;
        end else if (mix_done) begin
          a_d        = mix_a;
          b_d        = mix_b;
          c_d        = mix_c;
          mix_busy_d = 1'b0;
          if (state_q == TMIX) begin
            hash_d  = mix_c;
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end
      end

      DONE: begin
        if (bus.hash_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      cnt_q      <= 2'd0;
      owed_q     <= 2'd0;
      hash_q     <= '0;
      mix_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      owed_q     <= owed_d;
      hash_q     <= hash_d;
      mix_busy_q <= mix_busy_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.key_ready  = key_ready_c;
  assign bus.hash_valid = (state_q == DONE);
  assign bus.hash       = hash_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_lookup2_ctrl.sv
// Randomized scoreboard bench for lookup2_ctrl against a byte-level model of
// Bob Jenkins' lookup2 hash.
module tb_lookup2_ctrl;
  import lookup2_ctrl_pkg::*;

  localparam int LEN_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lookup2_ctrl_if #(.LEN_W(LEN_W)) bus();
  state_t dbg_state;

  lookup2_ctrl #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  kb [0:63];
  int          xfer_cnt = 0;
  int          jobs_done = 0;
  int          job_mark = 0;
  bit          manual_ready = 1'b0;
  logic        manual_val = 1'b0;
  logic [31:0] ga, gb, gc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void g_mix();
    ga = ga - gb; ga = ga - gc; ga = ga ^ (gc >> 13);
    gb = gb - gc; gb = gb - ga; gb = gb ^ (ga << 8);
    gc = gc - ga; gc = gc - gb; gc = gc ^ (gb >> 13);
    ga = ga - gb; ga = ga - gc; ga = ga ^ (gc >> 12);
    gb = gb - gc; gb = gb - ga; gb = gb ^ (ga << 16);
    gc = gc - ga; gc = gc - gb; gc = gc ^ (gb >> 5);
    ga = ga - gb; ga = ga - gc; ga = ga ^ (gc >> 3);
    gb = gb - gc; gb = gb - ga; gb = gb ^ (ga << 10);
    gc = gc - ga; gc = gc - gb; gc = gc ^ (gb >> 15);
  endfunction

  function automatic logic [31:0] word_at(input int k);
    return {kb[k+3], kb[k+2], kb[k+1], kb[k]};
  endfunction

  function automatic logic [31:0] golden(input int len, input logic [31:0] iv);
    int k;
    int rest;
    k = 0;
    rest = len;
    ga = 32'h9e3779b9;
    gb = 32'h9e3779b9;
    gc = iv;
    while (rest >= 12) begin
      ga = ga + word_at(k);
      gb = gb + word_at(k + 4);
      gc = gc + word_at(k + 8);
      g_mix();
      k = k + 12;
      rest = rest - 12;
    end
    gc = gc + 32'(len);
    for (int i = rest - 1; i >= 0; i--) begin
      if (i >= 8)      gc = gc + ({24'h0, kb[k+i]} << (8 * (i - 7)));
      else if (i >= 4) gb = gb + ({24'h0, kb[k+i]} << (8 * (i - 4)));
      else             ga = ga + ({24'h0, kb[k+i]} << (8 * i));
    end
    g_mix();
    return gc;
  endfunction

  // ---------------- consumer ready and monitor ----------------
  always @(posedge clk) begin
    #1;
    bus.hash_ready = manual_ready ? manual_val : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (rst_n && bus.key_valid && bus.key_ready) xfer_cnt++;
    if (rst_n && bus.hash_valid && bus.hash_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_hash: got %h, expected no result", bus.hash);
      end else begin
        check("hash", bus.hash, exp_q.pop_front());
      end
      jobs_done++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_bytes();
    for (int i = 0; i < 64; i++) kb[i] = 8'($urandom);
  endtask

  task automatic start_job(input int len, input logic [31:0] iv, input bit expect_it,
                           input bit release_rst);
    if (expect_it) exp_q.push_back(golden(len, iv));
    @(posedge clk);
    #1;
    xfer_cnt = 0;
    job_mark = jobs_done;
    bus.start = 1'b1;
    bus.initval = iv;
    bus.len = LEN_W'(len);
    if (release_rst) rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // mode 0: always valid, 1: valid every other cycle, 2: random valid
  task automatic feed_words(input int len, input int mode, input int max_words);
    int nw;
    int sent;
    int cyc;
    nw = (len + 3) / 4;
    if (nw > max_words) nw = max_words;
    sent = 0;
    cyc = 0;
    while (sent < nw && cyc < 400) begin
      case (mode)
        0:       bus.key_valid = 1'b1;
        1:       bus.key_valid = (cyc % 2 == 1);
        default: bus.key_valid = 1'($urandom_range(0, 1));
      endcase
      bus.key_data = word_at(4 * sent);
      @(negedge clk);
      if (bus.key_valid && bus.key_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.key_valid = 1'b0;
    if (sent < nw) begin
      checks++;
      errors++;
      $display("FAIL feed_timeout: sent %0d words, required %0d", sent, nw);
    end
  endtask

  // Junk words stay offered until the result handshake so over-consumption shows.
  task automatic finish_job(input int len);
    int cyc;
    cyc = 0;
    bus.key_valid = 1'b1;
    while (jobs_done == job_mark && cyc < 300) begin
      bus.key_data = $urandom;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.key_valid = 1'b0;
    check("job_done", 32'(jobs_done - job_mark), 32'd1);
    check("words", 32'(xfer_cnt), 32'((len + 3) / 4));
  endtask

  task automatic run_job(input int len, input logic [31:0] iv, input int mode);
    start_job(len, iv, 1'b1, 1'b0);
    feed_words(len, mode, 99);
    finish_job(len);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_key_ready"}, 32'(bus.key_ready), 32'd0);
    check({tag, "_hash_valid"}, 32'(bus.hash_valid), 32'd0);
    check({tag, "_hash"}, bus.hash, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] iv;
    logic [31:0] e;
    int cyc;
    int len;
    int mode;

    bus.start = 1'b0;
    bus.initval = '0;
    bus.len = '0;
    bus.key_valid = 1'b0;
    bus.key_data = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // Empty key, start on the very first edge after reset release.
    fill_bytes();
    start_job(0, 32'h0, 1'b1, 1'b1);
    check("first_start_busy", 32'(bus.busy), 32'd1);
    feed_words(0, 0, 99);
    finish_job(0);

    // One full block of bytes 00..0B.
    for (int i = 0; i < 64; i++) kb[i] = 8'(i);
    run_job(12, 32'h0, 0);

    // 13 bytes: last word all ones, only its low byte belongs to the key.
    fill_bytes();
    for (int i = 12; i < 16; i++) kb[i] = 8'hFF;
    run_job(13, 32'h12345678, 0);

    // Same 24-byte key unstalled and with key_valid toggling.
    fill_bytes();
    iv = $urandom;
    run_job(24, iv, 0);
    run_job(24, iv, 1);

    // Reset during the first block mix abandons the job.
    fill_bytes();
    start_job(24, $urandom, 1'b0, 1'b0);
    feed_words(24, 0, 3);
    cyc = 0;
    while (dbg_state != MIX && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("reach_mix", 32'(dbg_state == MIX), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midjob_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    fill_bytes();
    run_job(4, $urandom, 0);

    // Result held while the consumer stalls; starts meanwhile are ignored.
    fill_bytes();
    manual_ready = 1'b1;
    manual_val = 1'b0;
    start_job(8, $urandom, 1'b1, 1'b0);
    e = exp_q[0];
    feed_words(8, 0, 99);
    cyc = 0;
    while (!bus.hash_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("hold_reached", 32'(bus.hash_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.len = LEN_W'(4);
      bus.initval = $urandom;
      @(negedge clk);
      check("hold_valid", 32'(bus.hash_valid), 32'd1);
      check("hold_hash", bus.hash, e);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    manual_val = 1'b1;
    finish_job(8);
    manual_ready = 1'b0;
    @(negedge clk);
    check("start_ignored_busy", 32'(bus.busy), 32'd0);

    // Random lengths, keys, seeds and stall patterns.
    for (int j = 0; j < 12; j++) begin
      fill_bytes();
      len = $urandom_range(0, 48);
      mode = $urandom_range(0, 2);
      run_job(len, $urandom, mode);
    end

    repeat (5) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
